// File: rtl/ped_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ped_pkg
// Description : Shared definitions for the pedestrian crossing controller:
//               lamp pattern constants, decoded phase enum, FSM state enum
//               and the lamp decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ped_pkg;

  // Lamp patterns as {red, amb, gre}
  localparam logic [2:0] LAMP_RED     = 3'b100;
  localparam logic [2:0] LAMP_RED_AMB = 3'b110;
  localparam logic [2:0] LAMP_GREEN   = 3'b001;
  localparam logic [2:0] LAMP_AMBER   = 3'b010;

  typedef enum logic [2:0] {
    PH_RED     = 3'd0,
    PH_RED_AMB = 3'd1,
    PH_GREEN   = 3'd2,
    PH_AMBER   = 3'd3,
    PH_INVALID = 3'd4
  } phase_e;

  typedef enum logic [1:0] {
    ST_DW    = 2'd0,
    ST_WALK  = 2'd1,
    ST_FLASH = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  // Anything the sequencer should never produce (all-off, two lamps that
  // are not red+amber, all-on) decodes to INVALID.
  function automatic phase_e decode_phase(input logic [2:0] lamps);
    case (lamps)
      LAMP_RED:     return PH_RED;
      LAMP_RED_AMB: return PH_RED_AMB;
      LAMP_GREEN:   return PH_GREEN;
      LAMP_AMBER:   return PH_AMBER;
      default:      return PH_INVALID;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ped_crossing_if.sv
`default_nettype none
// ============================================================================
// Module      : ped_crossing_if
// Description : Signal bundle between the lamp sequencer / button side and
//               the crossing controller.
//               red, amb, gre  : lamp outputs of the traffic light sequencer
//               button         : pedestrian push button (level, synchronous)
//               walk           : green man
//               dont_walk      : red man
//               wait_lamp      : request pending indicator
//               fault          : illegal lamp pattern seen
//               master = sequencer/button side, slave = controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface ped_crossing_if;
  logic red;
  logic amb;
  logic gre;
  logic button;
  logic walk;
  logic dont_walk;
  logic wait_lamp;
  logic fault;

  modport master (
    output red, amb, gre, button,
    input  walk, dont_walk, wait_lamp, fault
  );

  modport slave (
    input  red, amb, gre, button,
    output walk, dont_walk, wait_lamp, fault
  );
endinterface
`default_nettype wire

// File: rtl/ped_req_latch.sv
`default_nettype none
// ============================================================================
// Module      : ped_req_latch
// Description : Button rising-edge detector and pedestrian request flag.
//               clk, rst_n   : clock, synchronous active-low reset
//               button       : pedestrian button level
//               inhibit      : when high a press does not set the request
//               clear        : clears the request (wins over a same-cycle set)
//               req          : registered request flag
//               req_or_set   : request flag OR a press accepted this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module ped_req_latch (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic button,
  input  wire logic inhibit,
  input  wire logic clear,
  output logic      req,
  output logic      req_or_set
);

  logic btn_q, btn_d;
  logic req_q, req_d;
  logic w_set;

  always_comb begin
    btn_d = button;
    w_set = button & ~btn_q & ~inhibit;
    req_d = req_q;
    if (clear) begin
      req_d = 1'b0;
    end else if (w_set) begin
      req_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_q <= 1'b0;
      req_q <= 1'b0;
    end else begin
      btn_q <= btn_d;
      req_q <= req_d;
    end
  end

  // The FSM needs to see a press made in the very cycle of red onset.
  assign req        = req_q;
  assign req_or_set = req_q | w_set;

endmodule
`default_nettype wire

// File: rtl/ped_crossing.sv
`default_nettype none
// ============================================================================
// Module      : ped_crossing
// Description : Pedestrian crossing controller downstream of the traffic
//               light sequencer. Grants WALK at red onset when a request is
//               pending, flashes the walk lamp for the rest of red, and forces
//               DON'T WALK outside red or on an illegal lamp pattern.
//               clk, rst_n : clock, synchronous active-low reset
//               pif        : ped_crossing_if.slave (lamps, button, outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module ped_crossing
  import ped_pkg::*;
#(
  parameter int WALK_CYC   = 8,
  parameter int FLASH_HALF = 2
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  ped_crossing_if.slave   pif
);

  localparam int CNT_MAX = (WALK_CYC > FLASH_HALF) ? WALK_CYC : FLASH_HALF;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] C_WALK_LAST  = CNT_W'(WALK_CYC - 1);
  localparam logic [CNT_W-1:0] C_FLASH_LAST = CNT_W'(FLASH_HALF - 1);

  state_e            state_q, state_d;
  phase_e            prev_phase_q, prev_phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              flash_q, flash_d;
  logic              walk_q, walk_d;
  logic              dont_walk_q, dont_walk_d;
  logic              fault_q, fault_d;

  phase_e            w_phase;
  logic              w_onset;
  logic              w_fault_cond;
  logic              w_req_inhibit;
  logic              w_req_clear;
  logic              w_req;
  logic              w_req_or_set;

  ped_req_latch u_req_latch (
    .clk        (clk),
    .rst_n      (rst_n),
    .button     (pif.button),
    .inhibit    (w_req_inhibit),
    .clear      (w_req_clear),
    .req        (w_req),
    .req_or_set (w_req_or_set)
  );

  assign w_phase       = decode_phase({pif.red, pif.amb, pif.gre});
  assign w_onset       = (w_phase == PH_RED) && (prev_phase_q == PH_AMBER);
  // An INVALID pattern straight out of reset (sequencer still starting up)
  // is tolerated; only a valid-to-invalid transition is a fault.
  assign w_fault_cond  = (w_phase == PH_INVALID) && (prev_phase_q != PH_INVALID);
  assign w_req_inhibit = (state_q == ST_WALK) || (state_q == ST_FLASH);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flash_d      = flash_q;
    w_req_clear  = 1'b0;
    prev_phase_d = w_phase;

    if (w_fault_cond) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_DW: begin
          if (w_onset && w_req_or_set) begin
            state_d     = ST_WALK;
            cnt_d       = '0;
            w_req_clear = 1'b1;
          end
        end
        ST_WALK: begin
          // Leaving red beats the steady-walk timer.
          if (w_phase != PH_RED) begin
            state_d = ST_DW;
          end else if (cnt_q == C_WALK_LAST) begin
            state_d = ST_FLASH;
            cnt_d   = '0;
            flash_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_FLASH: begin
          if (w_phase != PH_RED) begin
            state_d = ST_DW;
          end else if (cnt_q == C_FLASH_LAST) begin
            cnt_d   = '0;
            flash_d = ~flash_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_FAULT: begin
          if (w_phase == PH_GREEN) begin
            state_d = ST_DW;
          end
        end
        default: state_d = ST_FAULT;
      endcase
    end

    // Outputs are registered versions of the next-state decode, so they
    // change on the same edge as the state.
    walk_d      = (state_d == ST_WALK) || ((state_d == ST_FLASH) && flash_d);
    dont_walk_d = (state_d == ST_DW) || (state_d == ST_FAULT);
    fault_d     = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_DW;
      prev_phase_q <= PH_INVALID;
      cnt_q        <= '0;
      flash_q      <= 1'b0;
      walk_q       <= 1'b0;
      dont_walk_q  <= 1'b1;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_phase_q <= prev_phase_d;
      cnt_q        <= cnt_d;
      flash_q      <= flash_d;
      walk_q       <= walk_d;
      dont_walk_q  <= dont_walk_d;
      fault_q      <= fault_d;
    end
  end

  assign pif.walk      = walk_q;
  assign pif.dont_walk = dont_walk_q;
  assign pif.wait_lamp = w_req;
  assign pif.fault     = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_ped_crossing.sv
`default_nettype none
// ============================================================================
// Module      : tb_ped_crossing
// Description : Directed self-checking bench for ped_crossing
//               (WALK_CYC=8, FLASH_HALF=2). Outputs are compared as
//               {walk, dont_walk, wait_lamp, fault} one time unit after
//               each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ped_crossing;

  localparam logic [2:0] L_RED  = 3'b100;
  localparam logic [2:0] L_RA   = 3'b110;
  localparam logic [2:0] L_GRN  = 3'b001;
  localparam logic [2:0] L_AMB  = 3'b010;
  localparam logic [2:0] L_ALL  = 3'b111;
  localparam logic [2:0] L_OFF  = 3'b000;

  // {walk, dont_walk, wait_lamp, fault}
  localparam logic [3:0] O_DW      = 4'b0100;
  localparam logic [3:0] O_DW_WAIT = 4'b0110;
  localparam logic [3:0] O_WALK    = 4'b1000;
  localparam logic [3:0] O_FLASH0  = 4'b0000;
  localparam logic [3:0] O_FAULT   = 4'b0101;
  localparam logic [3:0] O_FAULT_W = 4'b0111;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  ped_crossing_if pif ();

  ped_crossing #(
    .WALK_CYC   (8),
    .FLASH_HALF (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pif   (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] outs();
    return {pif.walk, pif.dont_walk, pif.wait_lamp, pif.fault};
  endfunction

  // Drive one cycle of lamps/button and settle just after the edge.
  task automatic cyc(input logic [2:0] l, input logic b);
    {pif.red, pif.amb, pif.gre} = l;
    pif.button = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(L_OFF, 1'b0);
    cyc(L_OFF, 1'b0);
    tests++;
    if (outs() !== O_DW) begin
      $display("FAIL reset_values: got %b expected %b", outs(), O_DW);
      fails++;
    end
    rst_n = 1'b1;
    // All-off right after reset must not raise fault.
    cyc(L_OFF, 1'b0);
    tests++;
    if (outs() !== O_DW) begin
      $display("FAIL startup_invalid: got %b expected %b", outs(), O_DW);
      fails++;
    end
  endtask

  task automatic test_no_button();
    logic [2:0] seq [4] = '{L_GRN, L_AMB, L_RED, L_RA};
    int         len [4] = '{4, 4, 20, 4};
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < len[s]; i++) begin
        cyc(seq[s], 1'b0);
        tests++;
        if (outs() !== O_DW) begin
          $display("FAIL no_button seg%0d cyc%0d: got %b expected %b", s, i, outs(), O_DW);
          fails++;
        end
      end
    end
  endtask

  task automatic test_walk_flash();
    logic [3:0] exp;
    cyc(L_GRN, 1'b1);
    cyc(L_GRN, 1'b0);
    tests++;
    if (outs() !== O_DW_WAIT) begin
      $display("FAIL wf_request: got %b expected %b", outs(), O_DW_WAIT);
      fails++;
    end
    cyc(L_AMB, 1'b0);
    tests++;
    if (outs() !== O_DW_WAIT) begin
      $display("FAIL wf_amber: got %b expected %b", outs(), O_DW_WAIT);
      fails++;
    end
    for (int i = 0; i < 20; i++) begin
      // A press during WALK (i==3) must be ignored.
      cyc(L_RED, (i == 3) ? 1'b1 : 1'b0);
      if (i < 8) exp = O_WALK;
      else exp = {(((i - 8) / 2) % 2 == 1) ? 1'b1 : 1'b0, 3'b000};
      tests++;
      if (outs() !== exp) begin
        $display("FAIL wf_red cyc%0d: got %b expected %b", i, outs(), exp);
        fails++;
      end
    end
    cyc(L_RA, 1'b0);
    tests++;
    if (outs() !== O_DW) begin
      $display("FAIL wf_end: got %b expected %b", outs(), O_DW);
      fails++;
    end
  endtask

  task automatic test_short_red();
    logic [2:0] seq [9] = '{L_GRN, L_AMB, L_RED, L_RED, L_RED, L_RA, L_GRN, L_AMB, L_RED};
    logic [3:0] exp [9] = '{O_DW_WAIT, O_DW_WAIT, O_WALK, O_WALK, O_WALK, O_DW, O_DW, O_DW, O_DW};
    for (int i = 0; i < 9; i++) begin
      cyc(seq[i], (i == 0) ? 1'b1 : 1'b0);
      tests++;
      if (outs() !== exp[i]) begin
        $display("FAIL short_red step%0d: got %b expected %b", i, outs(), exp[i]);
        fails++;
      end
    end
  endtask

  task automatic test_late_press();
    logic [2:0] seq [17] = '{L_RA, L_GRN, L_AMB, L_RED, L_RED, L_RED, L_RED, L_RED,
                             L_RED, L_RED, L_RED, L_RED, L_RED, L_RA, L_GRN, L_AMB, L_RED};
    logic [3:0] exp [17] = '{O_DW, O_DW, O_DW, O_DW, O_DW, O_DW, O_DW, O_DW,
                             O_DW_WAIT, O_DW_WAIT, O_DW_WAIT, O_DW_WAIT, O_DW_WAIT,
                             O_DW_WAIT, O_DW_WAIT, O_DW_WAIT, O_WALK};
    for (int i = 0; i < 17; i++) begin
      cyc(seq[i], (i == 8) ? 1'b1 : 1'b0);
      tests++;
      if (outs() !== exp[i]) begin
        $display("FAIL late_press step%0d: got %b expected %b", i, outs(), exp[i]);
        fails++;
      end
    end
    cyc(L_RA, 1'b0);
    tests++;
    if (outs() !== O_DW) begin
      $display("FAIL late_press_end: got %b expected %b", outs(), O_DW);
      fails++;
    end
  endtask

  task automatic test_fault();
    logic [2:0] seq [12] = '{L_GRN, L_AMB, L_RED, L_RED, L_RED, L_ALL, L_RED, L_RED,
                             L_GRN, L_AMB, L_RED, L_RA};
    logic [3:0] exp [12] = '{O_DW_WAIT, O_DW_WAIT, O_WALK, O_WALK, O_WALK, O_FAULT,
                             O_FAULT, O_FAULT_W, O_DW_WAIT, O_DW_WAIT, O_WALK, O_DW};
    // Press at step 0 (request) and step 7 (inside FAULT, must be kept).
    for (int i = 0; i < 12; i++) begin
      cyc(seq[i], (i == 0 || i == 7) ? 1'b1 : 1'b0);
      tests++;
      if (outs() !== exp[i]) begin
        $display("FAIL fault step%0d: got %b expected %b", i, outs(), exp[i]);
        fails++;
      end
    end
  endtask

  task automatic test_reset_flash();
    logic [2:0] seq [6] = '{L_RED, L_RA, L_GRN, L_AMB, L_RED, L_RED};
    cyc(L_GRN, 1'b1);
    cyc(L_AMB, 1'b0);
    for (int i = 0; i < 10; i++) cyc(L_RED, 1'b0);
    tests++;
    if (outs() !== O_FLASH0) begin
      $display("FAIL rf_in_flash: got %b expected %b", outs(), O_FLASH0);
      fails++;
    end
    rst_n = 1'b0;
    cyc(L_RED, 1'b0);
    tests++;
    if (outs() !== O_DW) begin
      $display("FAIL rf_reset: got %b expected %b", outs(), O_DW);
      fails++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(seq[i], 1'b0);
      tests++;
      if (outs() !== O_DW) begin
        $display("FAIL rf_after step%0d: got %b expected %b", i, outs(), O_DW);
        fails++;
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    pif.red = 1'b0;
    pif.amb = 1'b0;
    pif.gre = 1'b0;
    pif.button = 1'b0;
    test_reset();
    test_no_button();
    test_walk_flash();
    test_short_red();
    test_late_press();
    test_fault();
    test_reset_flash();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
